// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: BCD nibble type and active-low g..a patterns.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

endpackage

// File: rtl/seg7_scan_mux_bcd_to_seg7.sv
// Combinational BCD nibble to active-low g..a pattern; codes 10..15 render blank.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] pattern
);

    // Nibble lookup
    always_comb begin
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with per-frame input snapshot and slot blanking.
// Optional leading-zero suppression: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]      BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1'b1);

    logic [DIV_W-1:0]             div_cnt_r;
    logic [IDX_W-1:0]             idx_r;
    bcd_t [NUM_DIGITS-1:0]        shadow_r;
    logic [NUM_DIGITS-1:0]        shadow_dp_r;
    logic                         tick_s;
    logic                         frame_s;
    logic                         blank_s;
    bcd_t                         cur_bcd_s;
    logic [6:0]                   cur_pat_s;
    logic [7:0]                   lit_seg_s;

    assign tick_s    = (div_cnt_r == DIV_LAST);
    assign frame_s   = tick_s && (idx_r == IDX_LAST);
    assign blank_s   = (div_cnt_r < BLANK_END);
    assign cur_bcd_s = shadow_r[idx_r];

    bcd_to_seg7 u_dec (
        .bcd     (cur_bcd_s),
        .pattern (cur_pat_s)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] mask_s;
    logic [NUM_DIGITS-1:0] mask_r;

    // Leading-zero mask from the live inputs, latched together with the snapshot
    always_comb begin
        logic lead_s;
        mask_s = {NUM_DIGITS{1'b0}};
        lead_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead_s && (digits[4*i +: 4] == 4'd0)) begin
                mask_s[i] = 1'b1;
            end else begin
                lead_s = 1'b0;
            end
        end
    end

    // Suppressed digits keep their anode but show nothing, dp included
    always_comb begin
        if (mask_r[idx_r]) begin
            lit_seg_s = SEG_ALL_OFF;
        end else begin
            lit_seg_s = {~shadow_dp_r[idx_r], cur_pat_s};
        end
    end

    // Mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= {NUM_DIGITS{1'b0}};
        end else if (frame_s) begin
            mask_r <= mask_s;
        end
    end
`else
    // Lit-slot segment pattern
    always_comb begin
        lit_seg_s = {~shadow_dp_r[idx_r], cur_pat_s};
    end
`endif

    // Prescaler, digit index, frame snapshot and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r   <= {DIV_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            shadow_r    <= {NUM_DIGITS{4'hF}};
            shadow_dp_r <= {NUM_DIGITS{1'b0}};
            frame_done  <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_ALL_OFF;
        end else begin
            if (tick_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
                idx_r     <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
            end

            // Snapshot only at the frame boundary so a scan never mixes old and new digits
            if (frame_s) begin
                shadow_r    <= digits;
                shadow_dp_r <= dp_in;
            end

            frame_done <= frame_s;

            if (blank_s) begin
                an  <= AN_OFF;
                seg <= SEG_ALL_OFF;
            end else begin
                an  <= ~(AN_ONE << idx_r);
                seg <= lit_seg_s;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1).
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0][7:0] exp;   // exp[i] = expected seg for digit i
    } vec_t;

    localparam int NVEC = 7;
    vec_t            vecs [NVEC];
    logic [3:0][7:0] prev_exp;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLANK_CYC  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One digit slot: one blank cycle then three lit cycles
    task automatic check_slot(input int d, input logic [7:0] exp_seg, input logic last);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << d);
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) begin
                check($sformatf("blank an d%0d", d), an, 4'hF);
                check($sformatf("blank seg d%0d", d), seg, 8'hFF);
            end else begin
                check($sformatf("an d%0d c%0d", d, c), an, exp_an);
                check($sformatf("seg d%0d c%0d", d, c), seg, exp_seg);
            end
            check($sformatf("frame_done d%0d c%0d", d, c), frame_done, last && (c == 3));
        end
    endtask

    task automatic check_frame(input logic [3:0][7:0] exp);
        for (int d = 0; d < 4; d++) begin
            check_slot(d, exp[d], d == 3);
        end
    endtask

    initial begin
        vecs[0] = {16'h1234, 4'b0000, 8'hF9, 8'hA4, 8'hB0, 8'h99};
        vecs[1] = {16'h5678, 4'b0000, 8'h92, 8'h82, 8'hF8, 8'h80};
        vecs[3] = {16'h89C1, 4'b0000, 8'h80, 8'h90, 8'hFF, 8'hF9};
        vecs[4] = {16'hABEF, 4'b1111, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vecs[2] = {16'h0009, 4'b0100, 8'hFF, 8'hFF, 8'hFF, 8'h90};
        vecs[5] = {16'h0070, 4'b0000, 8'hFF, 8'hFF, 8'hF8, 8'hC0};
        vecs[6] = {16'h0000, 4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'h40};
`else
        vecs[2] = {16'h0009, 4'b0100, 8'hC0, 8'h40, 8'hC0, 8'h90};
        vecs[5] = {16'h0070, 4'b0000, 8'hC0, 8'hC0, 8'hF8, 8'hC0};
        vecs[6] = {16'h0000, 4'b1111, 8'h40, 8'h40, 8'h40, 8'h40};
`endif

        rst    = 1'b1;
        digits = 16'h0000;
        dp_in  = 4'b0000;
        step();
        step();
        check("reset an", an, 4'hF);
        check("reset seg", seg, 8'hFF);
        check("reset frame_done", frame_done, 1'b0);
        rst = 1'b0;

        // Each frame shows what was captured at the end of the previous one
        prev_exp = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int v = 0; v < NVEC; v++) begin
            digits = vecs[v].digits;
            dp_in  = vecs[v].dp;
            check_frame(prev_exp);
            prev_exp = vecs[v].exp;
        end
        digits = 16'h1234;
        dp_in  = 4'b0000;
        check_frame(prev_exp);

        // Mid-frame input change must not tear the current scan
        check_slot(0, 8'h99, 1'b0);
        check_slot(1, 8'hB0, 1'b0);
        digits = 16'h5678;
        check_slot(2, 8'hA4, 1'b0);
        check_slot(3, 8'hF9, 1'b1);
        digits = 16'h1234;
        check_slot(0, 8'h80, 1'b0);
        check_slot(1, 8'hF8, 1'b0);

        // Reset while idx=2: everything back to reset values, blank frame follows
        step();
        check("pre-reset blank an", an, 4'hF);
        step();
        check("pre-reset an d2", an, 4'b1011);
        check("pre-reset seg d2", seg, 8'h82);
        rst = 1'b1;
        step();
        check("midscan reset an", an, 4'hF);
        check("midscan reset seg", seg, 8'hFF);
        check("midscan reset frame_done", frame_done, 1'b0);
        rst = 1'b0;
        check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF});
        check_frame({8'hF9, 8'hA4, 8'hB0, 8'h99});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
